// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multicycle controller: opcodes, funct codes,
// ALU commands, FSM state encodings, RegDst encodings and instruction classes.
// Imported by the instruction decoder and the controller top.
package multicycle_controller_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU commands
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd3;

    // Register-file write destination select
    localparam logic [1:0] RDST_RD  = 2'd0;
    localparam logic [1:0] RDST_RT  = 2'd1;
    localparam logic [1:0] RDST_R31 = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    // Instruction classes; the FSM sequences on these rather than raw opcodes.
    typedef enum logic [3:0] {
        CL_RTYPE = 4'd0,   // ADD/SUB/SLT
        CL_JR    = 4'd1,
        CL_J     = 4'd2,
        CL_JAL   = 4'd3,
        CL_BEQ   = 4'd4,
        CL_BNE   = 4'd5,
        CL_IMM   = 4'd6,   // ADDI/XORI
        CL_LW    = 4'd7,
        CL_SW    = 4'd8,
        CL_ILL   = 4'd15
    } iclass_t;

endpackage

// File: rtl/multicycle_controller_instr_decoder.sv
// Purely combinational instruction decoder: IR -> class, ALU controls, RegDst, illegal.
// Ports: ir_i (instruction register); cls_o, alu_cntrl_o, alu_src_o, reg_dst_o, illegal_o.
// Outputs are steady for as long as IR is held, so the FSM reuses them across states.
module instr_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [31:0] ir_i,
    output iclass_t     cls_o,
    output logic [2:0]  alu_cntrl_o,
    output logic        alu_src_o,
    output logic [1:0]  reg_dst_o,
    output logic        illegal_o
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_ir_bits;

    assign opcode = ir_i[31:26];
    assign funct  = ir_i[5:0];
    // Register and immediate fields are consumed by the top, not here.
    assign unused_ir_bits = ^ir_i[25:6];

    always_comb begin
        cls_o       = CL_ILL;
        alu_cntrl_o = ALU_ADD;
        alu_src_o   = 1'b0;
        reg_dst_o   = RDST_RD;
        illegal_o   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin cls_o = CL_RTYPE; alu_cntrl_o = ALU_ADD; end
                    FN_SUB: begin cls_o = CL_RTYPE; alu_cntrl_o = ALU_SUB; end
                    FN_SLT: begin cls_o = CL_RTYPE; alu_cntrl_o = ALU_SLT; end
                    FN_JR:  cls_o = CL_JR;
                    default: illegal_o = 1'b1;
                endcase
            end
            OP_J:    cls_o = CL_J;
            OP_JAL: begin cls_o = CL_JAL; reg_dst_o = RDST_R31; end
            OP_BEQ: begin cls_o = CL_BEQ; alu_cntrl_o = ALU_SUB; end
            OP_BNE: begin cls_o = CL_BNE; alu_cntrl_o = ALU_SUB; end
            OP_ADDI: begin
                cls_o = CL_IMM; alu_cntrl_o = ALU_ADD; alu_src_o = 1'b1; reg_dst_o = RDST_RT;
            end
            OP_XORI: begin
                cls_o = CL_IMM; alu_cntrl_o = ALU_XOR; alu_src_o = 1'b1; reg_dst_o = RDST_RT;
            end
            OP_LW: begin
                cls_o = CL_LW; alu_cntrl_o = ALU_ADD; alu_src_o = 1'b1; reg_dst_o = RDST_RT;
            end
            OP_SW: begin
                cls_o = CL_SW; alu_cntrl_o = ALU_ADD; alu_src_o = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU controller: fetches into IR, sequences FETCH/DECODE/EXEC/MEM/WB,
// drives datapath strobes and owns the PC (branches via alu_zero, JR via da).
// Ports: clk/reset; instr, alu_zero, da in; pc, register fields, strobes, link_addr, state_o, illegal out.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic [31:0] da,
    output logic [31:0] pc,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  r31,
    output logic [15:0] imm16,
    output logic        reg_wr,
    output logic [1:0]  reg_dst,
    output logic [2:0]  alu_cntrl,
    output logic        mem_wr,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic        wb_link,
    output logic [31:0] link_addr,
    output logic [2:0]  state_o,
    output logic        illegal
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_cur_q, pc_cur_d;   // address of the instruction held in IR
    logic [31:0] ir_q, ir_d;
    logic        illegal_q, illegal_d;

    iclass_t     dec_cls;
    logic [2:0]  dec_alu_cntrl;
    logic        dec_alu_src;
    logic [1:0]  dec_reg_dst;
    logic        dec_illegal;

    logic        reg_wr_c, mem_wr_c, wb_link_c;
    logic [31:0] jump_target;
    logic [31:0] branch_target;

    instr_decoder u_dec (
        .ir_i        (ir_q),
        .cls_o       (dec_cls),
        .alu_cntrl_o (dec_alu_cntrl),
        .alu_src_o   (dec_alu_src),
        .reg_dst_o   (dec_reg_dst),
        .illegal_o   (dec_illegal)
    );

    assign jump_target   = {pc_cur_q[31:28], ir_q[25:0], 2'b00};
    assign branch_target = pc_cur_q + 32'd4 + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            pc_cur_q  <= RESET_PC;
            ir_q      <= 32'h0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pc_cur_q  <= pc_cur_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_cur_d   = pc_cur_q;
        ir_d       = ir_q;
        illegal_d  = illegal_q;
        reg_wr_c   = 1'b0;
        mem_wr_c   = 1'b0;
        wb_link_c  = 1'b0;
        reg_dst    = RDST_RD;
        alu_cntrl  = ALU_ADD;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_d     = instr;
                pc_cur_d = pc_q;
                pc_d     = pc_q + 32'(PC_STEP);
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end else if (dec_cls == CL_J) begin
                    pc_d    = jump_target;
                    state_d = S_FETCH;
                end else if (dec_cls == CL_JAL) begin
                    // Link write happens here, while pc_cur still names the JAL.
                    pc_d      = jump_target;
                    reg_wr_c  = 1'b1;
                    reg_dst   = RDST_R31;
                    wb_link_c = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_cntrl = dec_alu_cntrl;
                alu_src   = dec_alu_src;
                case (dec_cls)
                    CL_RTYPE, CL_IMM: state_d = S_WB;
                    CL_LW, CL_SW:     state_d = S_MEM;
                    CL_BEQ: begin
                        if (alu_zero) pc_d = branch_target;
                        state_d = S_FETCH;
                    end
                    CL_BNE: begin
                        if (!alu_zero) pc_d = branch_target;
                        state_d = S_FETCH;
                    end
                    CL_JR: begin
                        pc_d    = da;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                alu_cntrl = dec_alu_cntrl;
                alu_src   = dec_alu_src;
                if (dec_cls == CL_SW) begin
                    mem_wr_c = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                alu_cntrl  = dec_alu_cntrl;
                alu_src    = dec_alu_src;
                reg_wr_c   = 1'b1;
                reg_dst    = dec_reg_dst;
                mem_to_reg = (dec_cls == CL_LW);
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                // Parked until reset; pc is not touched.
                illegal_d = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Write strobes are masked by reset so an aborted instruction cannot
    // write even while the flops are still settling into their reset state.
    assign reg_wr  = reg_wr_c  & ~reset;
    assign mem_wr  = mem_wr_c  & ~reset;
    assign wb_link = wb_link_c & ~reset;

    assign pc        = pc_q;
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign r31       = 5'd31;
    assign imm16     = ir_q[15:0];
    assign link_addr = pc_cur_q + 32'd8;
    assign state_o   = state_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: a small program in a bench-side
// instruction memory, per-cycle expectations queued by the driver and popped by a
// negedge checker, plus direct checks around asynchronous reset.
module tb_multicycle_controller;

    localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, T = 3'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        alu_zero;
    logic [31:0] da;
    logic [31:0] pc;
    logic [4:0]  rs, rt, rd, r31;
    logic [15:0] imm16;
    logic        reg_wr;
    logic [1:0]  reg_dst;
    logic [2:0]  alu_cntrl;
    logic        mem_wr;
    logic        mem_to_reg;
    logic        alu_src;
    logic        wb_link;
    logic [31:0] link_addr;
    logic [2:0]  state_o;
    logic        illegal;

    logic [31:0] imem [0:63];
    assign instr = imem[pc[7:2]];

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .alu_zero   (alu_zero),
        .da         (da),
        .pc         (pc),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .r31        (r31),
        .imm16      (imm16),
        .reg_wr     (reg_wr),
        .reg_dst    (reg_dst),
        .alu_cntrl  (alu_cntrl),
        .mem_wr     (mem_wr),
        .mem_to_reg (mem_to_reg),
        .alu_src    (alu_src),
        .wb_link    (wb_link),
        .link_addr  (link_addr),
        .state_o    (state_o),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [2:0]  st;
        logic [31:0] pc;
        logic        rw;
        logic [1:0]  rd;
        logic        mw;
        logic        m2r;
        logic        src;
        logic [2:0]  alu;
        logic        wbl;
    } exp_t;

    exp_t exp_q[$];

    task automatic push_exp(input logic [2:0] st, input logic [31:0] p, input logic rw,
                            input logic [1:0] rdst, input logic mw, input logic m2r,
                            input logic src, input logic [2:0] alu, input logic wbl);
        exp_t e;
        e.st = st; e.pc = p; e.rw = rw; e.rd = rdst; e.mw = mw;
        e.m2r = m2r; e.src = src; e.alu = alu; e.wbl = wbl;
        exp_q.push_back(e);
    endtask

    // Queue the expectation for the cycle the DUT is in now, then advance one cycle.
    task automatic cyc(input logic [2:0] st, input logic [31:0] p, input logic rw,
                       input logic [1:0] rdst, input logic mw, input logic m2r,
                       input logic src, input logic [2:0] alu, input logic wbl);
        push_exp(st, p, rw, rdst, mw, m2r, src, alu, wbl);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("state",      {29'd0, state_o}, {29'd0, e.st});
            check_eq("pc",         pc, e.pc);
            check_eq("reg_wr",     {31'd0, reg_wr}, {31'd0, e.rw});
            check_eq("reg_dst",    {30'd0, reg_dst}, {30'd0, e.rd});
            check_eq("mem_wr",     {31'd0, mem_wr}, {31'd0, e.mw});
            check_eq("mem_to_reg", {31'd0, mem_to_reg}, {31'd0, e.m2r});
            check_eq("alu_src",    {31'd0, alu_src}, {31'd0, e.src});
            check_eq("alu_cntrl",  {29'd0, alu_cntrl}, {29'd0, e.alu});
            check_eq("wb_link",    {31'd0, wb_link}, {31'd0, e.wbl});
            check_eq("illegal",    {31'd0, illegal}, {31'd0, (e.st == T)});
        end
        check_eq("wr_exclusive", {31'd0, reg_wr & mem_wr}, 32'd0);
    end

    // Writes actually committed at a clock edge.
    int rw_cnt = 0;
    int mw_cnt = 0;
    always @(posedge clk) begin
        if (reg_wr) rw_cnt++;
        if (mem_wr) mw_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
        imem[0]  = 32'h012A4020;   // ADD  $8,$9,$10
        imem[1]  = 32'h8D090004;   // LW   $9,4($8)
        imem[2]  = 32'h08000004;   // J    0x10
        imem[4]  = 32'h1000FFFF;   // BEQ  imm=-1
        imem[5]  = 32'h08000008;   // J    0x20
        imem[8]  = 32'h0C000010;   // JAL  0x40
        imem[16] = 32'h00000008;   // JR   $0
        imem[20] = 32'hAD090004;   // SW   $9,4($8)

        reset    = 1'b1;
        alu_zero = 1'b0;
        da       = 32'h0;
        #1;
        check_eq("rst_pc",      pc, 32'h0);
        check_eq("rst_state",   {29'd0, state_o}, 32'd0);
        check_eq("rst_illegal", {31'd0, illegal}, 32'd0);
        check_eq("rst_reg_wr",  {31'd0, reg_wr}, 32'd0);
        check_eq("r31",         {27'd0, r31}, 32'd31);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // ADD: 4 cycles, write in WB to Rd
        cyc(F, 32'h00, 0, 0, 0, 0, 0, 0, 0);
        cyc(D, 32'h04, 0, 0, 0, 0, 0, 0, 0);
        check_eq("add_rd", {27'd0, rd}, 32'd8);
        cyc(E, 32'h04, 0, 0, 0, 0, 0, 0, 0);
        cyc(W, 32'h04, 1, 0, 0, 0, 0, 0, 0);
        // LW: 5 cycles
        cyc(F, 32'h04, 0, 0, 0, 0, 0, 0, 0);
        cyc(D, 32'h08, 0, 0, 0, 0, 0, 0, 0);
        check_eq("lw_imm16", {16'd0, imm16}, 32'h0004);
        cyc(E, 32'h08, 0, 0, 0, 0, 1, 0, 0);
        cyc(M, 32'h08, 0, 0, 0, 0, 1, 0, 0);
        cyc(W, 32'h08, 1, 1, 0, 1, 1, 0, 0);
        // J to 0x10
        cyc(F, 32'h08, 0, 0, 0, 0, 0, 0, 0);
        cyc(D, 32'h0C, 0, 0, 0, 0, 0, 0, 0);
        // BEQ taken: back to 0x10
        alu_zero = 1'b1;
        cyc(F, 32'h10, 0, 0, 0, 0, 0, 0, 0);
        cyc(D, 32'h14, 0, 0, 0, 0, 0, 0, 0);
        cyc(E, 32'h14, 0, 0, 0, 0, 0, 1, 0);
        // BEQ not taken: fall through to 0x14
        alu_zero = 1'b0;
        cyc(F, 32'h10, 0, 0, 0, 0, 0, 0, 0);
        cyc(D, 32'h14, 0, 0, 0, 0, 0, 0, 0);
        cyc(E, 32'h14, 0, 0, 0, 0, 0, 1, 0);
        // J to 0x20
        cyc(F, 32'h14, 0, 0, 0, 0, 0, 0, 0);
        cyc(D, 32'h18, 0, 0, 0, 0, 0, 0, 0);
        // JAL to 0x40, link 0x28
        cyc(F, 32'h20, 0, 0, 0, 0, 0, 0, 0);
        check_eq("jal_link_addr", link_addr, 32'h28);
        cyc(D, 32'h24, 1, 2, 0, 0, 0, 0, 1);
        // JR to da
        da = 32'h50;
        cyc(F, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        cyc(D, 32'h44, 0, 0, 0, 0, 0, 0, 0);
        cyc(E, 32'h44, 0, 0, 0, 0, 0, 0, 0);
        // SW, reset asserted in the middle of MEM
        cyc(F, 32'h50, 0, 0, 0, 0, 0, 0, 0);
        cyc(D, 32'h54, 0, 0, 0, 0, 0, 0, 0);
        cyc(E, 32'h54, 0, 0, 0, 0, 1, 0, 0);
        push_exp(M, 32'h54, 0, 0, 1, 0, 1, 0, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("abort_mem_wr", {31'd0, mem_wr}, 32'd0);
        check_eq("abort_state",  {29'd0, state_o}, 32'd0);
        check_eq("abort_pc",     pc, 32'h0);
        @(posedge clk);
        #1;
        check_eq("reg_writes", rw_cnt, 32'd3);
        check_eq("mem_writes", mw_cnt, 32'd0);

        // Illegal opcode 0x3F at address 0
        imem[0] = 32'hFC000000;
        #1 reset = 1'b0;
        cyc(F, 32'h00, 0, 0, 0, 0, 0, 0, 0);
        cyc(D, 32'h04, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(T, 32'h04, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        check_eq("trap_rst_pc",      pc, 32'h0);
        check_eq("trap_rst_illegal", {31'd0, illegal}, 32'd0);
        check_eq("trap_rst_state",   {29'd0, state_o}, 32'd0);
        check_eq("queue_drained",    exp_q.size(), 32'd0);
        check_eq("reg_writes_end",   rw_cnt, 32'd3);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control-side initiator for the CPU datapath.
- Fetches each instruction into an instruction register and sequences it through a multicycle state machine.
- Drives the datapath control strobes (RegWr, RegDst, ALUcntrl, MemWr, MemToReg, ALUSrc) and the register/immediate fields.
- Owns the PC and uses the datapath's zero flag and Da to resolve branches and JR.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment per instruction.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- instr  input  32  instruction memory read data; combinational from pc.
- alu_zero  input  1  datapath Alu_zero.
- da  input  32  datapath Da (Rs read data), used by JR.
- pc  output  32  current PC; also the instruction memory address.
- rs, rt, rd  output  5 each  IR[25:21], IR[20:16], IR[15:11].
- r31  output  5  constant 5'd31.
- imm16  output  16  IR[15:0].
- reg_wr  output  1  RegWr.
- reg_dst  output  2  0=Rd, 1=Rt, 2=R31.
- alu_cntrl  output  3  ALU command.
- mem_wr  output  1  MemWr.
- mem_to_reg  output  1  MemToReg.
- alu_src  output  1  0=Db, 1=sign-extended imm.
- wb_link  output  1  1 selects link_addr in place of Op_end_result for Jal_out.
- link_addr  output  32  PC of the JAL plus 8.
- state_o  output  3  current state, for debug.
- illegal  output  1  sticky illegal-opcode flag.

Behaviour:
- Reset (asynchronous, immediate on assertion):
  - pc=RESET_PC, IR=0, state=FETCH, illegal=0.
  - reg_wr, mem_wr and wb_link drop to 0 combinationally.
  - Reset mid-instruction aborts the instruction with no register or memory write.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- FETCH:
  - IR<=instr; pc_cur<=pc.
  - pc<=pc+PC_STEP (mod 2^32, wraps silently).
  - Next state: DECODE.
- DECODE (operands are read from the register file):
  - J: pc<={pc_cur[31:28], IR[25:0], 2'b00}, next FETCH.
  - JAL: same PC update; reg_wr=1, reg_dst=2, wb_link=1 asserted in this cycle; next FETCH.
  - Illegal opcode or funct: next TRAP.
  - All other instructions: next EXEC.
- EXEC (drives alu_cntrl and alu_src):
  - R-type ADD/SUB/SLT: next WB.
  - ADDI/XORI: alu_src=1, next WB.
  - LW/SW: alu_src=1, cmd ADD, next MEM.
  - BEQ/BNE: cmd SUB, alu_src=0. Branch taken when alu_zero==1 (BEQ) or ==0 (BNE); then pc<=pc_cur+4+(sext(imm16)<<2). Next FETCH.
  - JR: pc<=da, next FETCH.
- MEM (holds the EXEC ALU controls):
  - SW: mem_wr=1 for exactly this cycle, next FETCH.
  - LW: next WB.
- WB (holds the ALU controls; reg_wr=1 for exactly one cycle; next FETCH):
  - R-type: reg_dst=0.
  - Immediate ops and LW: reg_dst=1.
  - LW also sets mem_to_reg=1.
- TRAP:
  - illegal=1; all strobes are 0 and pc is frozen.
  - Only reset exits this state.
- Latency (cycles per instruction):
  - J/JAL: 2.
  - BEQ/BNE/JR: 3.
  - SW and R-type/immediate ops: 4.
  - LW: 5.
- Strobe rules: reg_wr and mem_wr are never both high. Neither is asserted outside the states listed above.
- Opcodes:
  - R-type=0x00, with funct ADD=0x20, SUB=0x22, SLT=0x2A, JR=0x08.
  - J=0x02, JAL=0x03, BEQ=0x04, BNE=0x05, ADDI=0x08, XORI=0x0E, LW=0x23, SW=0x2B.
- ALU commands: ADD=0, SUB=1, XOR=2, SLT=3.
- Defaults in every state unless stated above: reg_dst=0, alu_cntrl=ADD, alu_src=0, mem_to_reg=0, wb_link=0.

Decomposition:
- Shared package holds:
  - opcode constants, funct constants, ALU command constants;
  - state encodings;
  - the RegDst encodings (RD=0, RT=1, R31=2).
- One sub-module, instr_decoder: purely combinational.
  - Input: IR. Outputs: instruction class, alu_cntrl, alu_src, reg_dst, illegal.
  - The FSM in multicycle_controller consumes these outputs.

Test Plan:
- Reset then ADD (0x012A4020): pc 0→4; states FETCH, DECODE, EXEC, WB; reg_wr=1 only in WB with reg_dst=0 and alu_cntrl=0.
- LW (0x8D090004): 5 cycles; alu_src=1 in EXEC/MEM/WB; mem_to_reg=1 and reg_dst=1 in WB; mem_wr stays 0 throughout.
- BEQ with imm16=0xFFFF at pc_cur=0x10:
  - alu_zero=1: pc=0x10 after EXEC.
  - alu_zero=0: pc=0x14.
- JAL at pc_cur=0x20 with target 0x40: reg_wr=1, reg_dst=2, wb_link=1, link_addr=0x28 in DECODE; pc=0x40 next cycle.
- Opcode 0x3F: state→TRAP and illegal=1; pc frozen for 10 cycles; reset returns pc=0, illegal=0.
- Reset asserted in MEM of SW: mem_wr falls within the same cycle without waiting for a clock edge; no write occurs; FSM is in FETCH at the first edge after reset release.
